// File: rtl/tnoc_packet_arbiter.sv
// Packet-level arbiter: grants one flit source from header to tail so packets
// never interleave. Response-class packets win over request-class packets,
// and a run counter bounds how long a waiting request can be starved.

// Per-source classification of the head packet.
module tnoc_packet_arbiter_lane (
    input  logic       request,
    input  logic [7:0] packet_type,
    output logic       eligible,
    output logic       is_response,
    output logic       invalid
);
    localparam logic [7:0] TNOC_INVALID_PACKET = 8'h00;

    // Bit 7 of the packet type marks the response class.
    always_comb begin
        invalid     = request && (packet_type == TNOC_INVALID_PACKET);
        eligible    = request && (packet_type != TNOC_INVALID_PACKET);
        is_response = packet_type[7];
    end
endmodule

module tnoc_packet_arbiter #(
    parameter int REQUESTERS        = 4,
    parameter int RESPONSE_PRIORITY = 1,
    parameter int MAX_RESPONSE_RUN  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQUESTERS-1:0]      i_request,
    input  logic [REQUESTERS-1:0][7:0] i_packet_type,
    input  logic                       i_acknowledge,
    input  logic                       i_tail,
    output logic [REQUESTERS-1:0]      o_grant,
    output logic                       o_grant_is_response,
    output logic                       o_invalid_request
);
    localparam int         PTR_W   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [3:0] MAX_RUN = 4'(MAX_RESPONSE_RUN);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQUESTERS - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        grant_idx;
    logic [3:0]              run_count;

    logic [REQUESTERS-1:0]   eligible;
    logic [REQUESTERS-1:0]   is_response;
    logic [REQUESTERS-1:0]   invalid;
    logic [REQUESTERS-1:0]   elig_resp;
    logic [REQUESTERS-1:0]   elig_req;
    logic [REQUESTERS-1:0]   cand;
    logic [REQUESTERS-1:0]   hi_mask;
    logic [REQUESTERS-1:0]   cand_hi;
    logic [REQUESTERS-1:0]   pick_onehot;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_resp;

    genvar g;
    generate
        for (g = 0; g < REQUESTERS; g++) begin : g_lane
            tnoc_packet_arbiter_lane u_lane (
                .request     (i_request[g]),
                .packet_type (i_packet_type[g]),
                .eligible    (eligible[g]),
                .is_response (is_response[g]),
                .invalid     (invalid[g])
            );
        end
    endgenerate

    // Candidate set: responses first unless a waiting request has hit its
    // starvation bound; otherwise everything eligible competes.
    always_comb begin
        elig_resp = eligible & is_response;
        elig_req  = eligible & ~is_response;
        cand      = eligible;
        if (RESPONSE_PRIORITY != 0) begin
            if ((|elig_resp) && (run_count < MAX_RUN))
                cand = elig_resp;
            else if ((run_count >= MAX_RUN) && (|elig_req))
                cand = elig_req;
        end
    end

    // Round-robin pick: lowest candidate at/after rr_ptr, else lowest overall.
    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < REQUESTERS; k++)
            hi_mask[k] = (PTR_W'(k) >= rr_ptr);
        cand_hi = cand & hi_mask;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (cand[k] && !(|cand_hi))
                pick_idx = PTR_W'(k);
            if (cand_hi[k])
                pick_idx = PTR_W'(k);
        end
        pick_onehot = '0;
        if (|cand)
            pick_onehot[pick_idx] = 1'b1;
        pick_resp = |(pick_onehot & is_response);
    end

    // Arbitration FSM: grant in IDLE, hold until the tail flit is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            o_grant             <= '0;
            o_grant_is_response <= 1'b0;
            o_invalid_request   <= 1'b0;
            rr_ptr              <= '0;
            grant_idx           <= '0;
            run_count           <= '0;
        end else begin
            o_invalid_request <= 1'b0;
            case (state)
                IDLE: begin
                    o_invalid_request <= |invalid;
                    if (|cand) begin
                        state               <= LOCKED;
                        o_grant             <= pick_onehot;
                        o_grant_is_response <= pick_resp;
                        grant_idx           <= pick_idx;
                        if ((RESPONSE_PRIORITY != 0) && pick_resp && (|elig_req))
                            run_count <= (run_count >= MAX_RUN) ? MAX_RUN : run_count + 4'd1;
                        else
                            run_count <= '0;
                    end
                end
                LOCKED: begin
                    if (i_acknowledge && i_tail) begin
                        state               <= IDLE;
                        o_grant             <= '0;
                        o_grant_is_response <= 1'b0;
                        rr_ptr              <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tnoc_packet_arbiter.sv
// Directed bench for tnoc_packet_arbiter: a per-cycle vector table plus
// hand-written sequences for reset behaviour.
module tb_tnoc_packet_arbiter;
    localparam logic [7:0] T_INV   = 8'h00;
    localparam logic [7:0] T_READ  = 8'h20;
    localparam logic [7:0] T_PWR   = 8'h40;
    localparam logic [7:0] T_RESP  = 8'h80;
    localparam logic [7:0] T_RESPD = 8'hA0;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0][7:0] typ;
    logic            ack;
    logic            tail;
    logic [3:0]      grant, grant2;
    logic            is_resp, is_resp2;
    logic            inv, inv2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][7:0] typ;
        logic            ack;
        logic            tail;
        logic [3:0]      g;
        logic            r;
        logic            inv;
        logic [3:0]      g2;
        logic            r2;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    tnoc_packet_arbiter dut (
        .clk(clk), .rst_n(rst_n), .i_request(req), .i_packet_type(typ),
        .i_acknowledge(ack), .i_tail(tail), .o_grant(grant),
        .o_grant_is_response(is_resp), .o_invalid_request(inv)
    );

    tnoc_packet_arbiter #(.MAX_RESPONSE_RUN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_request(req), .i_packet_type(typ),
        .i_acknowledge(ack), .i_tail(tail), .o_grant(grant2),
        .o_grant_is_response(is_resp2), .o_invalid_request(inv2)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][7:0] types(input logic [7:0] t0, t1, t2, t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic add2(input logic [3:0] rq, input logic [3:0][7:0] ty, input logic a, t,
                        input logic [3:0] g, input logic r, input logic iv,
                        input logic [3:0] g2, input logic r2);
        vec_t v;
        v.req = rq; v.typ = ty; v.ack = a; v.tail = t;
        v.g = g; v.r = r; v.inv = iv; v.g2 = g2; v.r2 = r2;
        vq.push_back(v);
    endtask

    task automatic add(input logic [3:0] rq, input logic [3:0][7:0] ty, input logic a, t,
                       input logic [3:0] g, input logic r, input logic iv);
        add2(rq, ty, a, t, g, r, iv, g, r);
    endtask

    // Entered at a negedge; each row drives, crosses one posedge, checks.
    task automatic run_q(input string nm);
        for (int i = 0; i < vq.size(); i++) begin
            req = vq[i].req; typ = vq[i].typ; ack = vq[i].ack; tail = vq[i].tail;
            @(posedge clk); #1;
            check($sformatf("%s[%0d] grant", nm, i), 8'(grant), 8'(vq[i].g));
            check($sformatf("%s[%0d] grant2", nm, i), 8'(grant2), 8'(vq[i].g2));
            check($sformatf("%s[%0d] invalid", nm, i), 8'(inv), 8'(vq[i].inv));
            if (vq[i].g != 4'b0)
                check($sformatf("%s[%0d] is_resp", nm, i), 8'(is_resp), 8'(vq[i].r));
            if (vq[i].g2 != 4'b0)
                check($sformatf("%s[%0d] is_resp2", nm, i), 8'(is_resp2), 8'(vq[i].r2));
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; ack = 1'b0; tail = 1'b0;
        @(posedge clk); #1;
        check("reset grant", 8'(grant), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0][7:0] rd4, t2, t3, t5, t4;
        rd4 = types(T_READ, T_READ, T_READ, T_READ);
        rst_n = 1'b0; req = 4'b1111; typ = rd4; ack = 1'b0; tail = 1'b0;
        #3;
        check("in reset grant", 8'(grant), 8'h0);
        check("in reset is_resp", 8'(is_resp), 8'h0);
        check("in reset invalid", 8'(inv), 8'h0);
        @(posedge clk); #1;
        check("in reset held grant", 8'(grant), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four request; single-flit packets rotate with a bubble each.
        add(4'b1111, rd4, 0, 0, 4'b0001, 0, 0);
        add(4'b1111, rd4, 1, 1, 4'b0000, 0, 0);
        add(4'b1111, rd4, 0, 0, 4'b0010, 0, 0);
        add(4'b1111, rd4, 1, 1, 4'b0000, 0, 0);
        add(4'b1111, rd4, 0, 0, 4'b0100, 0, 0);
        add(4'b1111, rd4, 1, 1, 4'b0000, 0, 0);
        add(4'b1111, rd4, 0, 0, 4'b1000, 0, 0);
        add(4'b1111, rd4, 1, 1, 4'b0000, 0, 0);
        run_q("rr");

        // 4-flit response from source 1; source 2 arrives mid-packet.
        t2 = types(T_INV, T_RESPD, T_READ, T_INV);
        add(4'b0010, t2, 0, 0, 4'b0010, 1, 0);
        add(4'b0010, t2, 1, 0, 4'b0010, 1, 0);
        add(4'b0110, t2, 1, 0, 4'b0010, 1, 0);
        add(4'b0110, t2, 0, 0, 4'b0010, 1, 0);
        add(4'b0110, t2, 1, 0, 4'b0010, 1, 0);
        add(4'b0110, t2, 1, 1, 4'b0000, 0, 0);
        add(4'b0100, t2, 0, 0, 4'b0100, 0, 0);
        add(4'b0100, t2, 1, 1, 4'b0000, 0, 0);
        run_q("lock");

        // Response on source 2 beats reads on 0 and 3; then rr from pointer 3.
        t3 = types(T_READ, T_INV, T_RESP, T_READ);
        add(4'b1101, t3, 0, 0, 4'b0100, 1, 0);
        add(4'b1101, t3, 1, 1, 4'b0000, 0, 0);
        add(4'b1001, t3, 0, 0, 4'b1000, 0, 0);
        add(4'b1001, t3, 1, 1, 4'b0000, 0, 0);
        add(4'b0001, t3, 0, 0, 4'b0001, 0, 0);
        add(4'b0001, t3, 1, 1, 4'b0000, 0, 0);
        run_q("prio");

        // Invalid type on source 0 is never granted and flags a pulse.
        t5 = types(T_INV, T_READ, T_INV, T_INV);
        add(4'b0011, t5, 0, 0, 4'b0010, 0, 1);
        add(4'b0011, t5, 1, 1, 4'b0000, 0, 0);
        add(4'b0001, t5, 0, 0, 4'b0000, 0, 1);
        add(4'b0001, t5, 0, 0, 4'b0000, 0, 1);
        add(4'b0000, t5, 0, 0, 4'b0000, 0, 0);
        run_q("inv");

        // Async reset while locked on source 3.
        req = 4'b1000; typ = rd4; ack = 1'b0; tail = 1'b0;
        @(posedge clk); #1;
        check("lock3 grant", 8'(grant), 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("async rst grant", 8'(grant), 8'h0);
        check("async rst grant2", 8'(grant2), 8'h0);
        check("async rst is_resp", 8'(is_resp), 8'h0);
        @(negedge clk);
        req = 4'b1111;
        @(posedge clk); #1;
        check("rst held grant", 8'(grant), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst grant", 8'(grant), 8'h01);
        check("post rst grant2", 8'(grant2), 8'h01);
        @(negedge clk);
        ack = 1'b1; tail = 1'b1;
        @(posedge clk); #1;
        check("post rst release", 8'(grant), 8'h0);
        @(negedge clk);
        ack = 1'b0; tail = 1'b0;
        do_reset();

        // Starvation bound: run limit 4 (dut) vs 2 (dut2).
        t4 = types(T_RESP, T_RESP, T_PWR, T_INV);
        add2(4'b0111, t4, 0, 0, 4'b0001, 1, 0, 4'b0001, 1);
        add2(4'b0111, t4, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
        add2(4'b0111, t4, 0, 0, 4'b0010, 1, 0, 4'b0010, 1);
        add2(4'b0111, t4, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
        add2(4'b0111, t4, 0, 0, 4'b0001, 1, 0, 4'b0100, 0);
        add2(4'b0111, t4, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
        add2(4'b0111, t4, 0, 0, 4'b0010, 1, 0, 4'b0001, 1);
        add2(4'b0111, t4, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
        add2(4'b0111, t4, 0, 0, 4'b0100, 0, 0, 4'b0010, 1);
        add2(4'b0111, t4, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
        add2(4'b0111, t4, 0, 0, 4'b0001, 1, 0, 4'b0100, 0);
        add2(4'b0111, t4, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
        run_q("run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
